ps2_hack_keyboard: RTL

- Upstream feeder of the Hack memory map's keyboard word: receives PS/2 scan-code set 2 frames and maintains the 16-bit Hack keyboard register.
- Output `kb` drives the memory block's `kb` input directly, which exposes it at address 24576.
- `kb` holds the Hack code of the most recently pressed, still-held key, and is 0 when no key is held.

---
 rtl/ps2_hack_keyboard.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/ps2_hack_keyboard.sv
// PS/2 scan-code set 2 receiver and decoder feeding the Hack keyboard word.
// kb holds the Hack code of the most recently pressed, still-held key (0 when none).
module ps2_hack_keyboard #(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [15:0] kb,
    output logic        key_valid,
    output logic        frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_EXT     = 2'd1;
    localparam logic [1:0] ST_BRK     = 2'd2;
    localparam logic [1:0] ST_EXT_BRK = 2'd3;

    function automatic logic [7:0] map_code(input logic ext, input logic shift,
                                            input logic [7:0] sc);
        logic [7:0] lo;
        logic [7:0] hi;
        lo = 8'd0;
        hi = 8'd0;
        if (ext) begin
            case (sc)
                8'h6B:   lo = 8'd130;
                8'h75:   lo = 8'd131;
                8'h74:   lo = 8'd132;
                8'h72:   lo = 8'd133;
                8'h6C:   lo = 8'd134;
                8'h69:   lo = 8'd135;
                8'h7D:   lo = 8'd136;
                8'h7A:   lo = 8'd137;
                8'h70:   lo = 8'd138;
                8'h71:   lo = 8'd139;
                8'h5A:   lo = 8'd128;
                default: lo = 8'd0;
            endcase
            hi = lo;
        end else begin
            case (sc)
                8'h1C: {lo, hi} = {8'd97,  8'd65};
                8'h32: {lo, hi} = {8'd98,  8'd66};
                8'h21: {lo, hi} = {8'd99,  8'd67};
                8'h23: {lo, hi} = {8'd100, 8'd68};
                8'h24: {lo, hi} = {8'd101, 8'd69};
                8'h2B: {lo, hi} = {8'd102, 8'd70};
                8'h34: {lo, hi} = {8'd103, 8'd71};
                8'h33: {lo, hi} = {8'd104, 8'd72};
                8'h43: {lo, hi} = {8'd105, 8'd73};
                8'h3B: {lo, hi} = {8'd106, 8'd74};
                8'h42: {lo, hi} = {8'd107, 8'd75};
                8'h4B: {lo, hi} = {8'd108, 8'd76};
                8'h3A: {lo, hi} = {8'd109, 8'd77};
                8'h31: {lo, hi} = {8'd110, 8'd78};
                8'h44: {lo, hi} = {8'd111, 8'd79};
                8'h4D: {lo, hi} = {8'd112, 8'd80};
                8'h15: {lo, hi} = {8'd113, 8'd81};
                8'h2D: {lo, hi} = {8'd114, 8'd82};
                8'h1B: {lo, hi} = {8'd115, 8'd83};
                8'h2C: {lo, hi} = {8'd116, 8'd84};
                8'h3C: {lo, hi} = {8'd117, 8'd85};
                8'h2A: {lo, hi} = {8'd118, 8'd86};
                8'h1D: {lo, hi} = {8'd119, 8'd87};
                8'h22: {lo, hi} = {8'd120, 8'd88};
                8'h35: {lo, hi} = {8'd121, 8'd89};
                8'h1A: {lo, hi} = {8'd122, 8'd90};
                // Digit row: unshifted digit, shifted US-layout symbol
                8'h16: {lo, hi} = {8'd49,  8'd33};
                8'h1E: {lo, hi} = {8'd50,  8'd64};
                8'h26: {lo, hi} = {8'd51,  8'd35};
                8'h25: {lo, hi} = {8'd52,  8'd36};
                8'h2E: {lo, hi} = {8'd53,  8'd37};
                8'h36: {lo, hi} = {8'd54,  8'd94};
                8'h3D: {lo, hi} = {8'd55,  8'd38};
                8'h3E: {lo, hi} = {8'd56,  8'd42};
                8'h46: {lo, hi} = {8'd57,  8'd40};
                8'h45: {lo, hi} = {8'd48,  8'd41};
                8'h0E: {lo, hi} = {8'd96,  8'd126};
                8'h4E: {lo, hi} = {8'd45,  8'd95};
                8'h55: {lo, hi} = {8'd61,  8'd43};
                8'h54: {lo, hi} = {8'd91,  8'd123};
                8'h5B: {lo, hi} = {8'd93,  8'd125};
                8'h5D: {lo, hi} = {8'd92,  8'd124};
                8'h4C: {lo, hi} = {8'd59,  8'd58};
                8'h52: {lo, hi} = {8'd39,  8'd34};
                8'h41: {lo, hi} = {8'd44,  8'd60};
                8'h49: {lo, hi} = {8'd46,  8'd62};
                8'h4A: {lo, hi} = {8'd47,  8'd63};
                8'h29: {lo, hi} = {8'd32,  8'd32};
                8'h5A: {lo, hi} = {8'd128, 8'd128};
                8'h66: {lo, hi} = {8'd129, 8'd129};
                8'h76: {lo, hi} = {8'd140, 8'd140};
                8'h05: {lo, hi} = {8'd141, 8'd141};
                8'h06: {lo, hi} = {8'd142, 8'd142};
                8'h04: {lo, hi} = {8'd143, 8'd143};
                8'h0C: {lo, hi} = {8'd144, 8'd144};
                8'h03: {lo, hi} = {8'd145, 8'd145};
                8'h0B: {lo, hi} = {8'd146, 8'd146};
                8'h83: {lo, hi} = {8'd147, 8'd147};
                8'h0A: {lo, hi} = {8'd148, 8'd148};
                8'h01: {lo, hi} = {8'd149, 8'd149};
                8'h09: {lo, hi} = {8'd150, 8'd150};
                8'h78: {lo, hi} = {8'd151, 8'd151};
                8'h07: {lo, hi} = {8'd152, 8'd152};
                default: {lo, hi} = {8'd0, 8'd0};
            endcase
        end
        return shift ? hi : lo;
    endfunction

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_prev;
    logic                   clk_s;
    logic                   data_s;
    logic                   ps2_fall;

    logic [3:0]    bit_cnt;
    logic [TW-1:0] to_cnt;
    logic [10:0]   shreg;
    logic [10:0]   frame_w;
    logic          frame_ok;
    logic [7:0]    rx_byte;
    logic          rx_vld;

    logic [1:0] state;
    logic       lshift;
    logic       rshift;
    logic [8:0] last_make;
    logic       ext;
    logic       brk;
    logic [8:0] key;
    logic [7:0] code;

    // Synchronizers idle high so a reset never manufactures a falling edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
            clk_prev  <= clk_s;
        end
    end

    assign clk_s    = clk_sync[SYNC_STAGES-1];
    assign data_s   = data_sync[SYNC_STAGES-1];
    assign ps2_fall = clk_prev & ~clk_s;

    // Frame image including the bit arriving on this edge: [0]=start, [8:1]=data, [9]=parity, [10]=stop
    assign frame_w  = {data_s, shreg[10:1]};
    assign frame_ok = ~frame_w[0] & (^frame_w[9:1]) & frame_w[10];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_cnt   <= 4'd0;
            to_cnt    <= '0;
            rx_vld    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_vld    <= 1'b0;
            frame_err <= 1'b0;
            if (ps2_fall) begin
                to_cnt <= '0;
                if (bit_cnt == 4'd10) begin
                    bit_cnt <= 4'd0;
                    if (frame_ok) rx_vld <= 1'b1;
                    else          frame_err <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end else if (bit_cnt != 4'd0) begin
                if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    bit_cnt   <= 4'd0;
                    to_cnt    <= '0;
                    frame_err <= 1'b1;
                end else begin
                    to_cnt <= to_cnt + 1'b1;
                end
            end else begin
                to_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (ps2_fall) shreg <= frame_w;
        if (ps2_fall && bit_cnt == 4'd10) rx_byte <= frame_w[8:1];
    end

    assign ext  = (state == ST_EXT) || (state == ST_EXT_BRK);
    assign brk  = (state == ST_BRK) || (state == ST_EXT_BRK);
    assign key  = {ext, rx_byte};
    assign code = map_code(ext, lshift | rshift, rx_byte);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            lshift    <= 1'b0;
            rshift    <= 1'b0;
            last_make <= 9'd0;
            kb        <= 16'd0;
            key_valid <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (rx_vld) begin
                if (state == ST_IDLE && rx_byte == 8'hE0) begin
                    state <= ST_EXT;
                end else if (rx_byte == 8'hF0 && !brk) begin
                    state <= ext ? ST_EXT_BRK : ST_BRK;
                end else if (state == ST_IDLE &&
                             rx_byte inside {8'hE1, 8'hAA, 8'hFA, 8'hEE, 8'hFE}) begin
                    state <= ST_IDLE;
                end else begin
                    state <= ST_IDLE;
                    if (!brk) begin
                        if (rx_byte == 8'h12)      lshift <= 1'b1;
                        else if (rx_byte == 8'h59) rshift <= 1'b1;
                        else if (code != 8'd0) begin
                            kb        <= {8'd0, code};
                            last_make <= key;
                            key_valid <= 1'b1;
                        end
                    end else begin
                        if (rx_byte == 8'h12)      lshift <= 1'b0;
                        else if (rx_byte == 8'h59) rshift <= 1'b0;
                        if (key == last_make) begin
                            kb        <= 16'd0;
                            last_make <= 9'd0;
                        end
                    end
                end
            end
        end
    end

endmodule
